// File: rtl/ic_74hc161_c.sv
// ic_74hc161_c: synchronous 4-bit binary counter in the style of the 74HC161.
// On each rising clk edge, the highest-priority active input wins:
// rst, then clr_n, then load_n, then count (enp & ent), otherwise hold.
// Optional feature macro: IC74HC161_RCO_EN. When it is defined, rco = ent & (out == all ones).
// When it is not defined, rco is tied to 0; the ports and the counting behaviour stay the same.
module ic_74hc161_c #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load_n,
    input  logic             enp,
    input  logic             ent,
    output logic [WIDTH-1:0] out,
    output logic             rco
);

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             count_en;
    logic             at_max;

    assign count_en = enp & ent;
    assign at_max   = (cnt_q == CNT_MAX);

    // Next-count selection; the if/else order encodes the per-edge priority.
    always_comb begin
        cnt_d = cnt_q;
        if (rst) begin
            cnt_d = CNT_ZERO;
        end else if (!clr_n) begin
            cnt_d = CNT_ZERO;
        end else if (!load_n) begin
            cnt_d = in;
        end else if (count_en) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Count register; every path, including reset, is synchronous.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign out = cnt_q;

`ifdef IC74HC161_RCO_EN
    // Ripple carry: purely combinational and gated only by ent.
    always_comb begin
        rco = ent & at_max;
    end
`else
    logic unused_rco_terms;

    // rco generation is compiled out, so the carry output is held low.
    always_comb begin
        rco = 1'b0;
    end

    assign unused_rco_terms = at_max;
`endif

endmodule

// File: tb/tb_ic_74hc161_c.sv
// Directed testbench for ic_74hc161_c. Each expected value is worked out by hand.
// If IC74HC161_RCO_EN is defined, the expected rco values follow the enabled behaviour.
module tb_ic_74hc161_c;

    logic       clk;
    logic       rst;
    logic       clr_n;
    logic [3:0] in;
    logic       load_n;
    logic       enp;
    logic       ent;
    logic [3:0] out;
    logic       rco;

    int checks;
    int errors;

`ifdef IC74HC161_RCO_EN
    localparam logic RCO_ON = 1'b1;
`else
    localparam logic RCO_ON = 1'b0;
`endif

    ic_74hc161_c #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .clr_n  (clr_n),
        .in     (in),
        .load_n (load_n),
        .enp    (enp),
        .ent    (ent),
        .out    (out),
        .rco    (rco)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] exp);
        checks++;
        assert (out === exp) else begin
            errors++;
            $error("FAIL %s: out observed %0d expected %0d", tag, out, exp);
        end
    endtask

    task automatic chk_rco(input string tag, input logic exp);
        checks++;
        assert (rco === exp) else begin
            errors++;
            $error("FAIL %s: rco observed %b expected %b", tag, rco, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; clr_n = 1'b1; load_n = 1'b1; enp = 1'b0; ent = 1'b0; in = 4'd0;

        // Reset
        tick();
        chk_out("reset_out", 4'd0);
        chk_rco("reset_rco", 1'b0);

        // 20 counting edges wrap once: 1..15, 0, 1..4
        rst = 1'b0; enp = 1'b1; ent = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk_out($sformatf("count_%0d", i), 4'(i));
            if (i == 15) chk_rco("count_rco_at15", RCO_ON);
            if (i == 16) chk_rco("count_rco_at0", 1'b0);
        end

        // Load 10 while counting is enabled, then count three more edges
        in = 4'b1010; load_n = 1'b0;
        tick();
        chk_out("load_10", 4'd10);
        load_n = 1'b1;
        tick(); tick(); tick();
        chk_out("count_to_13", 4'd13);

        // Clear, then count two edges
        clr_n = 1'b0;
        tick();
        chk_out("clear", 4'd0);
        clr_n = 1'b1;
        tick(); tick();
        chk_out("count_to_2", 4'd2);

        // Count is held when either enable is low
        enp = 1'b0; ent = 1'b1;
        tick();
        chk_out("hold_enp0", 4'd2);
        enp = 1'b1; ent = 1'b0;
        tick();
        chk_out("hold_ent0", 4'd2);

        // Load ignores the enables
        enp = 1'b0; ent = 1'b0; in = 4'd14; load_n = 1'b0;
        tick();
        chk_out("load_no_en", 4'd14);
        load_n = 1'b1; enp = 1'b1; ent = 1'b1;
        tick();
        chk_out("count_to_15", 4'd15);
        chk_rco("rco_at15_ent1", RCO_ON);
        enp = 1'b0;
        #1;
        chk_rco("rco_ignores_enp", RCO_ON);
        load_n = 1'b0;
        #1;
        chk_rco("rco_ignores_load_n", RCO_ON);
        load_n = 1'b1;
        ent = 1'b0;
        #1;
        chk_rco("rco_ent0", 1'b0);
        tick();
        chk_out("hold_15_ent0", 4'd15);
        chk_rco("rco_ent0_after_edge", 1'b0);

        // A load pulse that starts and ends between edges is not captured
        in = 4'd3; load_n = 1'b0;
        #2;
        load_n = 1'b1;
        tick();
        chk_out("glitch_ignored", 4'd15);

        // Counting past 15 wraps to 0
        enp = 1'b1; ent = 1'b1;
        tick();
        chk_out("wrap_to_0", 4'd0);

        // rst has priority over clr_n and load_n
        in = 4'd5; load_n = 1'b0;
        tick();
        chk_out("preload_5a", 4'd5);
        rst = 1'b1; clr_n = 1'b0; load_n = 1'b0; in = 4'b0111;
        tick();
        chk_out("prio_rst", 4'd0);

        // clr_n has priority over load_n
        rst = 1'b0; clr_n = 1'b1; in = 4'd5; load_n = 1'b0;
        tick();
        chk_out("preload_5b", 4'd5);
        clr_n = 1'b0; load_n = 1'b0; in = 4'b0111;
        tick();
        chk_out("prio_clr", 4'd0);

        // Load works with enp low
        clr_n = 1'b1; enp = 1'b0; load_n = 1'b0; in = 4'b0111;
        tick();
        chk_out("prio_load_enp0", 4'd7);

        // rst during counting zeroes the count; the next edge counts with no dead cycle
        load_n = 1'b1; enp = 1'b1; ent = 1'b1;
        tick();
        chk_out("count_to_8", 4'd8);
        rst = 1'b1;
        tick();
        chk_out("rst_midcount", 4'd0);
        rst = 1'b0;
        tick();
        chk_out("first_after_rst", 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
